// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: instruction memory, free-running word PC and a
// FIFO of fetched {pc, instruction} pairs. Optional FETCH_PERF_EN adds counters.
module inst_fetch_queue #(
  parameter int XLEN        = 32,
  parameter int IMEM_DEPTH  = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int RESET_PC    = 0,
  localparam int AW         = $clog2(IMEM_DEPTH),
  localparam int QW         = $clog2(QUEUE_DEPTH),
  localparam int CW         = QW + 1
) (
  input  logic            CLOCK_50,
  input  logic            RSTN_N,
  input  logic            prog_we,
  input  logic [AW-1:0]   prog_addr,
  input  logic [XLEN-1:0] prog_data,
  input  logic            redirect_valid,
  input  logic [AW-1:0]   redirect_pc,
  input  logic            inst_ready,
`ifdef FETCH_PERF_EN
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     flush_cnt,
`endif
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [AW-1:0]   inst_pc,
  output logic [CW-1:0]   queue_count
);

  logic [XLEN-1:0] imem   [IMEM_DEPTH];
  logic [XLEN-1:0] q_data [QUEUE_DEPTH];
  logic [AW-1:0]   q_pc   [QUEUE_DEPTH];

  logic [AW-1:0] pc;
  logic [QW-1:0] wr_ptr;
  logic [QW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          do_pop;
  logic          do_push;

  // NOTE: combinational logic uses blocking '=' and assigns every signal on
  // every path, so no latch can be inferred.
  always_comb begin
    full    = (count == CW'(QUEUE_DEPTH));
    do_pop  = 1'b0;
    do_push = 1'b0;
    if (!redirect_valid) begin
      do_pop  = inst_valid && inst_ready;
      do_push = !full || do_pop;
    end
  end

  // NOTE: imem has no reset; it maps onto RAM and is loaded through prog_we.
  // The FIFO reads imem[pc] at the same edge, so a colliding write yields the old word.
  always_ff @(posedge CLOCK_50) begin
    if (prog_we) imem[prog_addr] <= prog_data;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register updates
  // from pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      pc     <= AW'(RESET_PC);
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        pc     <= pc + AW'(1);
        wr_ptr <= wr_ptr + QW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + QW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Small flop-based queue storage is reset so the head reads zero out of reset.
  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (do_push) begin
      q_data[wr_ptr] <= imem[pc];
      q_pc[wr_ptr]   <= pc;
    end
  end

  assign inst_valid  = (count != '0);
  assign inst_data   = q_data[rd_ptr];
  assign inst_pc     = q_pc[rd_ptr];
  assign queue_count = count;

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (do_push && fetch_cnt != '1)        fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect_valid && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
